// File: rtl/logic_seq_unit_pkg.sv
// Shared definitions for the lane-serial bitwise logic unit:
// operation encodings and controller state codes.
package logic_seq_unit_pkg;

   typedef enum logic [1:0] {
      OP_AND = 2'b00,
      OP_OR  = 2'b01,
      OP_XOR = 2'b10,
      OP_NOR = 2'b11
   } op_t;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/logic_seq_unit_if.sv
// Request/response handshake bundle between a requester and logic_seq_unit.
interface logic_seq_unit_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             is_zero;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, out, is_zero
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, out, is_zero
   );
endinterface

// File: rtl/logic_seq_unit_lane_logic.sv
// Combinational bitwise operation on one LANE-bit slice of the operands.
module lane_logic #(
   parameter int LANE = 8
) (
   input  logic [1:0]      op,
   input  logic [LANE-1:0] a,
   input  logic [LANE-1:0] b,
   output logic [LANE-1:0] y
);
   import logic_seq_unit_pkg::*;

   always_comb begin
      y = '0;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NOR:  y = ~(a | b);
         default: y = '0;
      endcase
   end
endmodule

// File: rtl/logic_seq_unit.sv
// Sequential bitwise logic unit: computes one LANE-bit slice per cycle,
// LSB lane first, and holds the result until the consumer takes it.
module logic_seq_unit #(
   parameter int WIDTH = 32,
   parameter int LANE  = 8
) (
   input  logic              clk,
   input  logic              rst,
   logic_seq_unit_if.slave   bus
);
   import logic_seq_unit_pkg::*;

   localparam int N     = WIDTH / LANE;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   generate
      if ((LANE < 1) || (WIDTH % LANE != 0)) begin : g_param_check
         $error("logic_seq_unit: WIDTH must be an integer multiple of LANE");
      end
   endgenerate

   logic [1:0]       state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [1:0]       op_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] result_reg;
   logic [LANE-1:0]  a_lane;
   logic [LANE-1:0]  b_lane;
   logic [LANE-1:0]  lane_res;

   assign a_lane = a_reg[cnt_reg*LANE +: LANE];
   assign b_lane = b_reg[cnt_reg*LANE +: LANE];

   lane_logic #(
      .LANE (LANE)
   ) u_lane (
      .op (op_reg),
      .a  (a_lane),
      .b  (b_lane),
      .y  (lane_res)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         cnt_reg    <= '0;
         op_reg     <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         result_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  op_reg     <= bus.op;
                  a_reg      <= bus.a;
                  b_reg      <= bus.b;
                  result_reg <= '0;
                  cnt_reg    <= '0;
                  state_reg  <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               result_reg[cnt_reg*LANE +: LANE] <= lane_res;
               cnt_reg <= cnt_reg + CNT_W'(1);
               if (cnt_reg == CNT_W'(N - 1)) begin
                  state_reg <= ST_DONE;
               end
            end
            ST_DONE: begin
               // Returning to IDLE here means a new request waits one more cycle.
               if (bus.out_ready) begin
                  state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state_reg == ST_IDLE);
   assign bus.out_valid = (state_reg == ST_DONE);
   assign bus.out       = result_reg;
   assign bus.is_zero   = (result_reg == '0);

endmodule
